// File: rtl/udp_loopback_pkt_buf_pkg.sv
// Shared widths, the descriptor record that travels from the rx commit logic to the replay FSM, and the FSM states.
package udp_lb_pkg;

  localparam int MAC_W  = 48;
  localparam int IP_W   = 32;
  localparam int PORT_W = 16;
  localparam int LEN_W  = 16;

  typedef struct packed {
    logic [LEN_W-1:0]  len;
    logic [MAC_W-1:0]  mac;
    logic [IP_W-1:0]   ip;
    logic [PORT_W-1:0] port;
  } desc_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_SEND
  } rd_state_e;

endpackage

// File: rtl/udp_loopback_pkt_buf_if.sv
// Payload/metadata bundle between the GMII UDP rx/tx engines and the loopback buffer.
// The slave side is the buffer; the master side is the rx/tx engine pair.
interface udp_loopback_pkt_buf_if
  import udp_lb_pkg::*;
#(
  parameter int DATA_W = 8
);

  logic [MAC_W-1:0]  rx_src_mac;
  logic [IP_W-1:0]   rx_src_ip;
  logic [PORT_W-1:0] rx_src_port;
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic              rx_pkt_done;
  logic              rx_pkt_err;

  logic              tx_en_pulse;
  logic [MAC_W-1:0]  tx_dst_mac;
  logic [IP_W-1:0]   tx_dst_ip;
  logic [PORT_W-1:0] tx_dst_port;
  logic [LEN_W-1:0]  tx_len;
  logic              tx_req;
  logic [DATA_W-1:0] tx_data;
  logic              tx_done;

  modport master (
    output rx_src_mac, rx_src_ip, rx_src_port, rx_valid, rx_data, rx_pkt_done, rx_pkt_err,
    output tx_req, tx_done,
    input  tx_en_pulse, tx_dst_mac, tx_dst_ip, tx_dst_port, tx_len, tx_data
  );

  modport slave (
    input  rx_src_mac, rx_src_ip, rx_src_port, rx_valid, rx_data, rx_pkt_done, rx_pkt_err,
    input  tx_req, tx_done,
    output tx_en_pulse, tx_dst_mac, tx_dst_ip, tx_dst_port, tx_len, tx_data
  );

endinterface

// File: rtl/udp_loopback_pkt_buf_sync_fifo.sv
// Show-ahead synchronous FIFO: dout is the head entry combinationally, pop takes effect next cycle.
// Push while full and pop while empty are ignored; D must be a power of 2 and at least 2.
module sync_fifo #(
  parameter int W = 8,
  parameter int D = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(D);
  localparam logic [PW:0] ONE_P = (PW+1)'(1);

  logic [W-1:0] mem_q [D];
  logic [PW:0]  wr_q, wr_d, rd_q, rd_d;
  logic         do_push, do_pop;

  assign full    = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign empty   = (wr_q == rd_q);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_q[PW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + ONE_P;
    if (do_pop)  rd_d = rd_q + ONE_P;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[PW-1:0]] <= din;
  end

endmodule

// File: rtl/udp_loopback_pkt_buf.sv
// Store-and-forward UDP loopback: commits good rx payloads with sender metadata, replays them to the tx engine.
// tx_data follows tx_req by one cycle; rx has no backpressure, so packets that cannot be held are rolled back.
module udp_loopback_pkt_buf
  import udp_lb_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4096,
  parameter int PKT_SLOTS = 8,
  parameter int MAX_LEN   = 1472,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 loop_en,
  udp_loopback_pkt_buf_if.slave lb,
  output logic [15:0]          pkt_ok_cnt,
  output logic [15:0]          pkt_err_cnt,
  output logic [15:0]          pkt_drop_cnt,
  output logic [AW:0]          free_bytes
);

  localparam logic [AW:0]      DEPTH_P   = (AW+1)'(DEPTH);
  localparam logic [AW:0]      PTR_ONE   = (AW+1)'(1);
  localparam logic [LEN_W-1:0] MAX_LEN_P = LEN_W'(MAX_LEN);

  // write side
  logic [AW:0]      wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             drop_q, drop_d;
  logic [15:0]      ok_cnt_q, ok_cnt_d, err_cnt_q, err_cnt_d, drop_cnt_q, drop_cnt_d;
  logic             ram_we;
  desc_t            desc_in;
  logic             fifo_push;

  // read side
  rd_state_e         state_q, state_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d, base_q, base_d;
  logic [LEN_W-1:0]  sent_q, sent_d;
  logic [MAC_W-1:0]  tx_dst_mac_q, tx_dst_mac_d;
  logic [IP_W-1:0]   tx_dst_ip_q, tx_dst_ip_d;
  logic [PORT_W-1:0] tx_dst_port_q, tx_dst_port_d;
  logic [LEN_W-1:0]  tx_len_q, tx_len_d;
  logic              byte_ok_q, byte_ok_d;
  logic              ram_re, fifo_pop;
  logic [AW:0]       free_bytes_q, free_bytes_d;

  desc_t             fifo_dout;
  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] ram_q [DEPTH];
  logic [DATA_W-1:0] ram_rdata_q;

  sync_fifo #(
    .W($bits(desc_t)),
    .D(PKT_SLOTS)
  ) u_desc_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (fifo_push),
    .din  (desc_in),
    .pop  (fifo_pop),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (ram_we) ram_q[wr_ptr_q[AW-1:0]] <= lb.rx_data;
    if (ram_re) ram_rdata_q <= ram_q[rd_ptr_q[AW-1:0]];
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    cnt_d        = cnt_q;
    drop_d       = drop_q;
    ok_cnt_d     = ok_cnt_q;
    err_cnt_d    = err_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    ram_we       = 1'b0;
    fifo_push    = 1'b0;
    desc_in      = '{len: cnt_q, mac: lb.rx_src_mac, ip: lb.rx_src_ip, port: lb.rx_src_port};

    // Once a packet is marked dropped, its remaining bytes are neither written nor counted.
    if (lb.rx_valid && !drop_q) begin
      if (((wr_ptr_q - rd_ptr_q) == DEPTH_P) || ((cnt_q == '0) && fifo_full) ||
          (cnt_q == MAX_LEN_P)) begin
        drop_d = 1'b1;
      end else begin
        ram_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        cnt_d    = cnt_q + 16'd1;
      end
    end

    if (lb.rx_pkt_err) begin
      wr_ptr_d  = commit_ptr_q;
      err_cnt_d = err_cnt_q + 16'd1;
      cnt_d     = '0;
      drop_d    = 1'b0;
    end else if (lb.rx_pkt_done) begin
      if (drop_d || (cnt_d == '0)) begin
        wr_ptr_d   = commit_ptr_q;
        drop_cnt_d = drop_cnt_q + 16'd1;
      end else begin
        desc_in.len  = cnt_d;
        fifo_push    = 1'b1;
        commit_ptr_d = wr_ptr_d;
        ok_cnt_d     = ok_cnt_q + 16'd1;
      end
      cnt_d  = '0;
      drop_d = 1'b0;
    end
  end

  always_comb begin
    state_d       = state_q;
    rd_ptr_d      = rd_ptr_q;
    base_d        = base_q;
    sent_d        = sent_q;
    tx_dst_mac_d  = tx_dst_mac_q;
    tx_dst_ip_d   = tx_dst_ip_q;
    tx_dst_port_d = tx_dst_port_q;
    tx_len_d      = tx_len_q;
    byte_ok_d     = 1'b0;
    ram_re        = 1'b0;
    fifo_pop      = 1'b0;
    free_bytes_d  = DEPTH_P - (commit_ptr_q - rd_ptr_q);

    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          if (loop_en) begin
            tx_dst_mac_d  = fifo_dout.mac;
            tx_dst_ip_d   = fifo_dout.ip;
            tx_dst_port_d = fifo_dout.port;
            tx_len_d      = fifo_dout.len;
            base_d        = rd_ptr_q;
            sent_d        = '0;
            state_d       = ST_START;
          end else begin
            fifo_pop = 1'b1;
            rd_ptr_d = rd_ptr_q + (AW+1)'(fifo_dout.len);
          end
        end
      end
      ST_START: state_d = ST_SEND;
      ST_SEND: begin
        if (lb.tx_req && (sent_q < tx_len_q)) begin
          ram_re    = 1'b1;
          byte_ok_d = 1'b1;
          rd_ptr_d  = rd_ptr_q + PTR_ONE;
          sent_d    = sent_q + 16'd1;
        end
        // Realign on the descriptor length even if the tx engine read fewer bytes.
        if (lb.tx_done) begin
          fifo_pop = 1'b1;
          rd_ptr_d = base_q + (AW+1)'(tx_len_q);
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      commit_ptr_q  <= '0;
      cnt_q         <= '0;
      drop_q        <= 1'b0;
      ok_cnt_q      <= '0;
      err_cnt_q     <= '0;
      drop_cnt_q    <= '0;
      state_q       <= ST_IDLE;
      rd_ptr_q      <= '0;
      base_q        <= '0;
      sent_q        <= '0;
      tx_dst_mac_q  <= '0;
      tx_dst_ip_q   <= '0;
      tx_dst_port_q <= '0;
      tx_len_q      <= '0;
      byte_ok_q     <= 1'b0;
      free_bytes_q  <= DEPTH_P;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      commit_ptr_q  <= commit_ptr_d;
      cnt_q         <= cnt_d;
      drop_q        <= drop_d;
      ok_cnt_q      <= ok_cnt_d;
      err_cnt_q     <= err_cnt_d;
      drop_cnt_q    <= drop_cnt_d;
      state_q       <= state_d;
      rd_ptr_q      <= rd_ptr_d;
      base_q        <= base_d;
      sent_q        <= sent_d;
      tx_dst_mac_q  <= tx_dst_mac_d;
      tx_dst_ip_q   <= tx_dst_ip_d;
      tx_dst_port_q <= tx_dst_port_d;
      tx_len_q      <= tx_len_d;
      byte_ok_q     <= byte_ok_d;
      free_bytes_q  <= free_bytes_d;
    end
  end

  assign lb.tx_en_pulse = (state_q == ST_START);
  assign lb.tx_dst_mac  = tx_dst_mac_q;
  assign lb.tx_dst_ip   = tx_dst_ip_q;
  assign lb.tx_dst_port = tx_dst_port_q;
  assign lb.tx_len      = tx_len_q;
  assign lb.tx_data     = byte_ok_q ? ram_rdata_q : '0;
  assign pkt_ok_cnt     = ok_cnt_q;
  assign pkt_err_cnt    = err_cnt_q;
  assign pkt_drop_cnt   = drop_cnt_q;
  assign free_bytes     = free_bytes_q;

endmodule
